cache_axi_bridge: RTL and testbench

CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

---
 rtl/cache_axi_bridge_if.sv | 91 +++++++++
 rtl/cache_axi_bridge.sv | 240 ++++++++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_axi_bridge_if.sv
// cache_axi_bridge_if
//   Groups the cache-side request/return signals and the five AXI channels
//   (AR, R, AW, W, B) that the bridge connects.
//   modport master : the bridge. It is a target for cache requests and an
//                    AXI master towards memory.
//   modport slave  : the environment, meaning the cache plus the AXI memory.
interface cache_axi_bridge_if;
  // cache read request / return
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;
  // cache write request
  logic        wr_req;
  logic [2:0]  wr_type;
  logic [31:0] wr_addr;
  logic [3:0]  wr_wstrb;
  logic [127:0] wr_data;
  logic        wr_rdy;
  // AXI AR
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  // AXI R
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // AXI AW
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  // AXI W
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // AXI B
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  rd_req, rd_type, rd_addr,
    output rd_rdy, ret_valid, ret_last, ret_data,
    input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output wr_rdy,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output rd_req, rd_type, rd_addr,
    input  rd_rdy, ret_valid, ret_last, ret_data,
    output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  wr_rdy,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge
//   Converts cache read and write requests into AXI bursts.
//   Reads  : type 3'b110 is a 4-beat x 32-bit INCR line fill. Types
//            3'b000/001/010 are single beats of 1, 2 or 4 bytes. Returned R
//            beats go straight back to the cache on ret_*.
//   Writes : the 128-bit line or word is buffered at accept time and sent
//            out one 32-bit beat at a time, word0 first.
//   The read and write engines are independent. A read to a line that has a
//   write in flight, or that is being accepted in the same cycle, is held
//   off until that write has its B response.
// Ports
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : cache_axi_bridge_if.master (cache request/return and AXI AR/R/AW/W/B)
// Parameters
//   RD_ID : ARID driven on every read burst
//   WR_ID : AWID driven on every write burst
module cache_axi_bridge #(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic                clk,
  input  logic                rst,
  cache_axi_bridge_if.master  bus
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;

  // Request-type decode
  function automatic logic is_line(input logic [2:0] t);
    return t == 3'b110;
  endfunction

  function automatic logic [7:0] burst_len(input logic [2:0] t);
    return is_line(t) ? 8'd3 : 8'd0;
  endfunction

  function automatic logic [2:0] burst_size(input logic [2:0] t);
    return is_line(t) ? 3'd2 : {1'b0, t[1:0]};
  endfunction

  function automatic logic [31:0] burst_addr(input logic [2:0] t, input logic [31:0] a);
    return is_line(t) ? {a[31:4], 4'b0000} : a;
  endfunction

  // Read engine state
  rd_state_t   rd_state;
  logic [31:0] ar_addr_q;
  logic [7:0]  ar_len_q;
  logic [2:0]  ar_size_q;
  logic        arvalid_q;
  logic        rready_q;

  // Write engine state
  wr_state_t    wr_state;
  logic [31:0]  aw_addr_q;
  logic [7:0]   aw_len_q;
  logic [2:0]   aw_size_q;
  logic [3:0]   wstrb_q;
  logic [127:0] wbuf_q;
  logic [1:0]   wcnt_q;
  logic         awvalid_q;
  logic         wvalid_q;
  logic         bready_q;

  logic        wr_rdy_w;
  logic        wr_accept;
  logic        hazard;
  logic        rd_rdy_w;
  logic        rd_accept;
  logic        w_last_beat;
  logic [31:0] wdata_w;

  assign wr_rdy_w  = (wr_state == W_IDLE);
  assign wr_accept = bus.wr_req & wr_rdy_w;

  // A read must not overtake a write to the same 16-byte line. That covers a
  // write already buffered and one being accepted in this very cycle. The
  // latched AW address keeps the raw [31:4] bits for both line and word writes.
  assign hazard = ((wr_state != W_IDLE) && (bus.rd_addr[31:4] == aw_addr_q[31:4])) ||
                  (wr_accept && (bus.rd_addr[31:4] == bus.wr_addr[31:4]));

  assign rd_rdy_w  = (rd_state == R_IDLE) & ~hazard;
  assign rd_accept = bus.rd_req & rd_rdy_w;

  // Read FSM: idle -> address -> data -> idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state  <= R_IDLE;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_size_q <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (rd_accept) begin
            ar_addr_q <= burst_addr(bus.rd_type, bus.rd_addr);
            ar_len_q  <= burst_len(bus.rd_type);
            ar_size_q <= burst_size(bus.rd_type);
            arvalid_q <= 1'b1;
            rd_state  <= R_AR;
          end
        end
        R_AR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            rd_state  <= R_DATA;
          end
        end
        R_DATA: begin
          if (bus.rvalid && bus.rlast) begin
            rready_q <= 1'b0;
            rd_state <= R_IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          rd_state  <= R_IDLE;
        end
      endcase
    end
  end

  // The beat counter only needs 2 bits because bursts are 1 or 4 beats long.
  assign w_last_beat = ({6'b0, wcnt_q} == aw_len_q);

  // Write FSM: idle -> address -> data beats -> response -> idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state  <= W_IDLE;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
      aw_size_q <= '0;
      wstrb_q   <= '0;
      wbuf_q    <= '0;
      wcnt_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (wr_accept) begin
            aw_addr_q <= burst_addr(bus.wr_type, bus.wr_addr);
            aw_len_q  <= burst_len(bus.wr_type);
            aw_size_q <= burst_size(bus.wr_type);
            wstrb_q   <= is_line(bus.wr_type) ? 4'hF : bus.wr_wstrb;
            wbuf_q    <= bus.wr_data;
            awvalid_q <= 1'b1;
            wr_state  <= W_AW;
          end
        end
        W_AW: begin
          if (bus.awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wcnt_q    <= 2'd0;
            wr_state  <= W_DATA;
          end
        end
        W_DATA: begin
          if (bus.wready) begin
            if (w_last_beat) begin
              wvalid_q <= 1'b0;
              bready_q <= 1'b1;
              wr_state <= W_RESP;
            end else begin
              wcnt_q <= wcnt_q + 2'd1;
            end
          end
        end
        W_RESP: begin
          if (bus.bvalid) begin
            bready_q <= 1'b0;
            wr_state <= W_IDLE;
          end
        end
        default: begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
          wr_state  <= W_IDLE;
        end
      endcase
    end
  end

  // Beat select from the line buffer, word0 = bits 31:0
  always_comb begin
    wdata_w = wbuf_q[31:0];
    case (wcnt_q)
      2'd0: wdata_w = wbuf_q[31:0];
      2'd1: wdata_w = wbuf_q[63:32];
      2'd2: wdata_w = wbuf_q[95:64];
      2'd3: wdata_w = wbuf_q[127:96];
      default: wdata_w = wbuf_q[31:0];
    endcase
  end

  // Cache-side outputs. Returned data is a zero-latency pass-through of R.
  assign bus.rd_rdy    = rd_rdy_w;
  assign bus.wr_rdy    = wr_rdy_w;
  assign bus.ret_valid = bus.rvalid & (rd_state == R_DATA);
  assign bus.ret_last  = bus.rlast & (rd_state == R_DATA);
  assign bus.ret_data  = bus.rdata;

  // AXI read address and read data
  assign bus.arid    = RD_ID;
  assign bus.araddr  = ar_addr_q;
  assign bus.arlen   = ar_len_q;
  assign bus.arsize  = ar_size_q;
  assign bus.arburst = BURST_INCR;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;

  // AXI write address, data and response
  assign bus.awid    = WR_ID;
  assign bus.awaddr  = aw_addr_q;
  assign bus.awlen   = aw_len_q;
  assign bus.awsize  = aw_size_q;
  assign bus.awburst = BURST_INCR;
  assign bus.awvalid = awvalid_q;
  assign bus.wdata   = wdata_w;
  assign bus.wstrb   = wstrb_q;
  assign bus.wlast   = wvalid_q & w_last_beat;
  assign bus.wvalid  = wvalid_q;
  assign bus.bready  = bready_q;

  // Response IDs and codes are not used by this bridge.
  logic unused_ok;
  assign unused_ok = ^{bus.rid, bus.rresp, bus.bid, bus.bresp};

endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb_cache_axi_bridge
//   Directed bench for cache_axi_bridge. It uses decode tables for reads and
//   writes, followed by hand-written sequences for the same-line hazard,
//   concurrent traffic and reset in the middle of a burst.
module tb_cache_axi_bridge;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  cache_axi_bridge_if bus();

  cache_axi_bridge #(.RD_ID(4'd0), .WR_ID(4'd1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] exp_addr;
    logic [7:0]  exp_len;
    logic [2:0]  exp_size;
    int          ar_delay;
    logic [31:0] data0;
  } rd_vec_t;

  typedef struct {
    logic [2:0]   typ;
    logic [31:0]  addr;
    logic [3:0]   strb;
    logic [127:0] data;
    logic [31:0]  exp_addr;
    logic [7:0]   exp_len;
    logic [2:0]   exp_size;
    logic [3:0]   exp_strb;
    logic [7:0]   wr_pat;
  } wr_vec_t;

  rd_vec_t rv[5];
  wr_vec_t wv[4];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_issue(input logic [2:0] t, input logic [31:0] a);
    bus.rd_req  = 1'b1;
    bus.rd_type = t;
    bus.rd_addr = a;
    @(negedge clk);
    chk("rd_rdy_at_req", bus.rd_rdy, 1);
    step();
    bus.rd_req = 1'b0;
  endtask

  task automatic ar_chk(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size);
    chk("arvalid", bus.arvalid, 1);
    chk("araddr", bus.araddr, a);
    chk("arlen", bus.arlen, len);
    chk("arsize", bus.arsize, size);
    chk("arburst", bus.arburst, 2'b01);
    chk("arid", bus.arid, 4'd0);
  endtask

  task automatic ar_phase(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                          input int delay);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      ar_chk(a, len, size);
      step();
    end
    bus.arready = 1'b1;
    @(negedge clk);
    ar_chk(a, len, size);
    step();
    bus.arready = 1'b0;
  endtask

  task automatic r_phase(input logic [31:0] d0, input int n);
    for (int i = 0; i < n; i++) begin
      bus.rvalid = 1'b1;
      bus.rdata  = d0 + i;
      bus.rlast  = (i == n - 1);
      @(negedge clk);
      chk("rready", bus.rready, 1);
      chk("ret_valid", bus.ret_valid, 1);
      chk("ret_data", bus.ret_data, d0 + i);
      chk("ret_last", bus.ret_last, (i == n - 1));
      step();
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    @(negedge clk);
    chk("rd_rdy_after_read", bus.rd_rdy, 1);
    chk("rready_after_read", bus.rready, 0);
    chk("ret_valid_after_read", bus.ret_valid, 0);
    step();
  endtask

  task automatic wr_issue(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                          input logic [127:0] d);
    bus.wr_req   = 1'b1;
    bus.wr_type  = t;
    bus.wr_addr  = a;
    bus.wr_wstrb = s;
    bus.wr_data  = d;
    @(negedge clk);
    chk("wr_rdy_at_req", bus.wr_rdy, 1);
    step();
    bus.wr_req   = 1'b0;
    bus.wr_data  = '0;
    bus.wr_wstrb = 4'h0;
  endtask

  task automatic aw_chk(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size);
    chk("awvalid", bus.awvalid, 1);
    chk("awaddr", bus.awaddr, a);
    chk("awlen", bus.awlen, len);
    chk("awsize", bus.awsize, size);
    chk("awburst", bus.awburst, 2'b01);
    chk("awid", bus.awid, 4'd1);
    chk("wr_rdy_busy", bus.wr_rdy, 0);
  endtask

  task automatic aw_phase(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                          input int delay);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      aw_chk(a, len, size);
      step();
    end
    bus.awready = 1'b1;
    @(negedge clk);
    aw_chk(a, len, size);
    step();
    bus.awready = 1'b0;
  endtask

  task automatic w_phase(input logic [127:0] d, input logic [7:0] len, input logic [3:0] s,
                         input logic [7:0] pat);
    int cnt = 0;
    for (int c = 0; c < 16 && cnt <= int'(len); c++) begin
      bus.wready = pat[c % 8];
      @(negedge clk);
      chk("wvalid", bus.wvalid, 1);
      chk("wdata", bus.wdata, d[cnt*32 +: 32]);
      chk("wstrb", bus.wstrb, s);
      chk("wlast", bus.wlast, (cnt == int'(len)));
      step();
      if (pat[c % 8]) cnt++;
    end
    bus.wready = 1'b0;
    chk("w_beats_done", cnt, int'(len) + 1);
  endtask

  task automatic b_phase();
    @(negedge clk);
    chk("bready", bus.bready, 1);
    chk("wvalid_in_resp", bus.wvalid, 0);
    chk("wr_rdy_in_resp", bus.wr_rdy, 0);
    step();
    bus.bvalid = 1'b1;
    @(negedge clk);
    chk("bready_at_bvalid", bus.bready, 1);
    step();
    bus.bvalid = 1'b0;
    @(negedge clk);
    chk("wr_rdy_after_b", bus.wr_rdy, 1);
    chk("bready_after_b", bus.bready, 0);
    step();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_arvalid"}, bus.arvalid, 0);
    chk({tag, "_awvalid"}, bus.awvalid, 0);
    chk({tag, "_wvalid"}, bus.wvalid, 0);
    chk({tag, "_wlast"}, bus.wlast, 0);
    chk({tag, "_rready"}, bus.rready, 0);
    chk({tag, "_bready"}, bus.bready, 0);
    chk({tag, "_ret_valid"}, bus.ret_valid, 0);
    chk({tag, "_ret_last"}, bus.ret_last, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;

    rv[0] = '{3'b110, 32'h1C00_0124, 32'h1C00_0120, 8'd3, 3'd2, 2, 32'h0000_000A};
    rv[1] = '{3'b000, 32'h0000_0043, 32'h0000_0043, 8'd0, 3'd0, 0, 32'h0000_00AB};
    rv[2] = '{3'b001, 32'h0000_0102, 32'h0000_0102, 8'd0, 3'd1, 1, 32'h0000_CAFE};
    rv[3] = '{3'b010, 32'h8000_0FFC, 32'h8000_0FFC, 8'd0, 3'd2, 0, 32'hDEAD_BEEF};
    rv[4] = '{3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 8'd3, 3'd2, 1, 32'h1234_0000};

    wv[0] = '{3'b110, 32'h0000_1000, 4'h0, 128'h4444_4444_3333_3333_2222_2222_1111_1111,
              32'h0000_1000, 8'd3, 3'd2, 4'hF, 8'b1010_1010};
    wv[1] = '{3'b010, 32'h0000_0008, 4'b0011, 128'h0_0000_0000_0000_0000_0000_0000_5566_7788,
              32'h0000_0008, 8'd0, 3'd2, 4'b0011, 8'b0000_0110};
    wv[2] = '{3'b000, 32'h0000_0105, 4'b0010, 128'h9999_8888_7777_6666_5555_4444_3333_00AA,
              32'h0000_0105, 8'd0, 3'd0, 4'b0010, 8'b1111_1111};
    wv[3] = '{3'b110, 32'h0000_ABCD, 4'h1, 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001,
              32'h0000_ABC0, 8'd3, 3'd2, 4'hF, 8'b0110_0110};

    rst = 1'b1;
    bus.rd_req = 1'b0; bus.rd_type = 3'b000; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.wr_type = 3'b000; bus.wr_addr = '0;
    bus.wr_wstrb = 4'h0; bus.wr_data = '0;
    bus.arready = 1'b0;
    bus.rid = 4'hF; bus.rdata = '0; bus.rresp = 2'b10; bus.rlast = 1'b0; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bid = 4'hF; bus.bresp = 2'b10; bus.bvalid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rd_rdy_post_reset", bus.rd_rdy, 1);
    chk("wr_rdy_post_reset", bus.wr_rdy, 1);
    step();

    // Read decode table
    for (int i = 0; i < 5; i++) begin
      rd_issue(rv[i].typ, rv[i].addr);
      ar_phase(rv[i].exp_addr, rv[i].exp_len, rv[i].exp_size, rv[i].ar_delay);
      r_phase(rv[i].data0, int'(rv[i].exp_len) + 1);
    end

    // Write decode table
    for (int i = 0; i < 4; i++) begin
      wr_issue(wv[i].typ, wv[i].addr, wv[i].strb, wv[i].data);
      aw_phase(wv[i].exp_addr, wv[i].exp_len, wv[i].exp_size, 1);
      w_phase(wv[i].data, wv[i].exp_len, wv[i].exp_strb, wv[i].wr_pat);
      b_phase();
    end

    // Hazard: line write to 0x2000 in flight blocks a read to 0x2008. A read
    // to 0x3000 still goes through while the write waits for awready.
    wr_issue(3'b110, 32'h0000_2000, 4'h0, 128'h0D0D_0D0D_0C0C_0C0C_0B0B_0B0B_0A0A_0A0A);
    bus.rd_req = 1'b1; bus.rd_type = 3'b010; bus.rd_addr = 32'h0000_2008;
    @(negedge clk);
    chk("haz_blocked_aw", bus.rd_rdy, 0);
    step();
    bus.rd_addr = 32'h0000_3000;
    @(negedge clk);
    chk("haz_other_line_ok", bus.rd_rdy, 1);
    step();
    bus.rd_req = 1'b0;
    ar_phase(32'h0000_3000, 8'd0, 3'd2, 0);
    r_phase(32'h0000_0055, 1);
    bus.rd_req = 1'b1; bus.rd_addr = 32'h0000_2008;
    @(negedge clk);
    chk("haz_blocked_again", bus.rd_rdy, 0);
    chk("haz_no_arvalid", bus.arvalid, 0);
    step();
    aw_phase(32'h0000_2000, 8'd3, 3'd2, 0);
    w_phase(128'h0D0D_0D0D_0C0C_0C0C_0B0B_0B0B_0A0A_0A0A, 8'd3, 4'hF, 8'hFF);
    @(negedge clk);
    chk("haz_blocked_resp", bus.rd_rdy, 0);
    step();
    bus.bvalid = 1'b1;
    step();
    bus.bvalid = 1'b0;
    @(negedge clk);
    chk("haz_released_rd", bus.rd_rdy, 1);
    chk("haz_released_wr", bus.wr_rdy, 1);
    step();
    bus.rd_req = 1'b0;
    ar_phase(32'h0000_2008, 8'd0, 3'd2, 0);
    r_phase(32'h0000_0077, 1);

    // A write being accepted in the same cycle blocks a read to its line.
    bus.wr_req = 1'b1; bus.wr_type = 3'b110; bus.wr_addr = 32'h0000_4000;
    bus.wr_data = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
    bus.rd_req = 1'b1; bus.rd_type = 3'b010; bus.rd_addr = 32'h0000_4004;
    @(negedge clk);
    chk("same_cycle_haz_rd", bus.rd_rdy, 0);
    chk("same_cycle_haz_wr", bus.wr_rdy, 1);
    step();
    bus.wr_req = 1'b0;
    aw_phase(32'h0000_4000, 8'd3, 3'd2, 0);
    w_phase(128'h0000_0004_0000_0003_0000_0002_0000_0001, 8'd3, 4'hF, 8'hFF);
    b_phase();
    bus.rd_req = 1'b0;
    ar_phase(32'h0000_4004, 8'd0, 3'd2, 0);
    r_phase(32'h0000_0099, 1);

    // Simultaneous accept of a read and a write to different lines
    bus.wr_req = 1'b1; bus.wr_type = 3'b010; bus.wr_addr = 32'h0000_5000;
    bus.wr_wstrb = 4'hF; bus.wr_data = 128'h0_0000_0000_0000_0000_0000_0000_0BAD_F00D;
    bus.rd_req = 1'b1; bus.rd_type = 3'b010; bus.rd_addr = 32'h0000_6000;
    @(negedge clk);
    chk("simul_rd_rdy", bus.rd_rdy, 1);
    chk("simul_wr_rdy", bus.wr_rdy, 1);
    step();
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    ar_phase(32'h0000_6000, 8'd0, 3'd2, 0);
    r_phase(32'h0000_BEEF, 1);
    aw_phase(32'h0000_5000, 8'd0, 3'd2, 0);
    w_phase(128'h0_0000_0000_0000_0000_0000_0000_0BAD_F00D, 8'd0, 4'hF, 8'hFF);
    b_phase();

    // Reset asserted during the second R beat of a line read
    rd_issue(3'b110, 32'h0000_0100);
    ar_phase(32'h0000_0100, 8'd3, 3'd2, 0);
    bus.rvalid = 1'b1; bus.rdata = 32'h0000_0001; bus.rlast = 1'b0;
    @(negedge clk);
    chk("mid_beat1_ret", bus.ret_valid, 1);
    step();
    bus.rdata = 32'h0000_0002;
    @(negedge clk);
    chk("mid_beat2_ret", bus.ret_valid, 1);
    rst = 1'b1;
    #1;
    chk_idle_outputs("mid_reset");
    step();
    bus.rvalid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rd_rdy_after_mid_reset", bus.rd_rdy, 1);
    chk("wr_rdy_after_mid_reset", bus.wr_rdy, 1);
    chk("rready_after_mid_reset", bus.rready, 0);
    step();
    rd_issue(3'b000, 32'h0000_0203);
    ar_phase(32'h0000_0203, 8'd0, 3'd0, 1);
    r_phase(32'h0000_00C3, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
